uart_tx_fifo: RTL and testbench

Byte queue directly upstream of the UART transmitter. Accepts bytes from producer logic on a valid/ready handshake, buffers up to DEPTH of them, and drains them one at a time into the UART's send/busy handshake. Producers can therefore burst bytes at clock rate without tracking the 115 200 Bd pacing themselves.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_fifo_mem.sv | 24 ++
 rtl/uart_tx_fifo.sv | 119 +++++++++++
 tb/tb_uart_tx_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the transmit-side FIFO.
package uart_pkg;

  localparam int unsigned UART_TX_FIFO_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } tTxFifoState;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 byte storage: synchronous write, asynchronous read, no reset on contents.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_TX_FIFO_DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          ipClk,
  input  logic          ipWrEn,
  input  logic [AW-1:0] ipWrAddr,
  input  logic [7:0]    ipWrData,
  input  logic [AW-1:0] ipRdAddr,
  output logic [7:0]    opRdData
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge ipClk) begin
    if (ipWrEn) mem[ipWrAddr] <= ipWrData;
  end

  assign opRdData = mem[ipRdAddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter over its send/busy handshake.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_TX_FIFO_DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          ipClk,
  input  logic          ipReset,
  input  logic [7:0]    ipData,
  input  logic          ipValid,
  output logic          opReady,
  output logic [7:0]    opTxData,
  output logic          opTxSend,
  input  logic          ipTxBusy,
`ifdef UART_TX_FIFO_OVERFLOW_EN
  output logic          opOverflow,
  input  logic          ipOverflowClear,
`endif
  output logic [AW:0]   opCount,
  output logic          opEmpty,
  output logic          opFull
);

  tTxFifoState   stateQ, stateD;
  logic [AW-1:0] wrPtrQ, rdPtrQ;
  logic [AW:0]   countQ;
  logic [7:0]    txDataQ, txDataD;
  logic [7:0]    headData;
  logic          push, pop;

  // Full/empty come from the registered count, so a pop never frees a slot for the same edge.
  assign opCount  = countQ;
  assign opEmpty  = (countQ == '0);
  assign opFull   = (countQ == (AW+1)'(DEPTH));
  assign opReady  = !opFull;
  assign opTxData = txDataQ;
  assign push     = ipValid && opReady;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uMem (
    .ipClk    (ipClk),
    .ipWrEn   (push),
    .ipWrAddr (wrPtrQ),
    .ipWrData (ipData),
    .ipRdAddr (rdPtrQ),
    .opRdData (headData)
  );

  always_comb begin
    stateD   = stateQ;
    txDataD  = txDataQ;
    pop      = 1'b0;
    opTxSend = 1'b0;
    case (stateQ)
      IDLE: begin
        if (!opEmpty && !ipTxBusy) begin
          stateD  = SEND;
          txDataD = headData;
        end
      end
      SEND: begin
        opTxSend = 1'b1;
        // Busy rising means the UART has taken the byte; release the slot now.
        if (ipTxBusy) begin
          pop    = 1'b1;
          stateD = WAIT;
        end
      end
      WAIT: begin
        if (!ipTxBusy) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      stateQ  <= IDLE;
      txDataQ <= 8'h00;
      wrPtrQ  <= '0;
      rdPtrQ  <= '0;
      countQ  <= '0;
    end else begin
      stateQ  <= stateD;
      txDataQ <= txDataD;
      if (push) wrPtrQ <= wrPtrQ + AW'(1);
      if (pop)  rdPtrQ <= rdPtrQ + AW'(1);
      case ({push, pop})
        2'b10:   countQ <= countQ + (AW+1)'(1);
        2'b01:   countQ <= countQ - (AW+1)'(1);
        default: countQ <= countQ;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflowQ;

  // Set has priority over clear on the same edge.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      overflowQ <= 1'b0;
    end else if (ipValid && opFull) begin
      overflowQ <= 1'b1;
    end else if (ipOverflowClear) begin
      overflowQ <= 1'b0;
    end
  end

  assign opOverflow = overflowQ;
`else
  // Without the flag, pushes into a full FIFO are dropped silently.
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a simple in-line UART busy model.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          ipClk = 1'b0;
  logic          ipReset;
  logic [7:0]    ipData;
  logic          ipValid;
  logic          opReady;
  logic [7:0]    opTxData;
  logic          opTxSend;
  logic          ipTxBusy;
  logic [AW:0]   opCount;
  logic          opEmpty;
  logic          opFull;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic          opOverflow;
  logic          ipOverflowClear;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .ipClk           (ipClk),
    .ipReset         (ipReset),
    .ipData          (ipData),
    .ipValid         (ipValid),
    .opReady         (opReady),
    .opTxData        (opTxData),
    .opTxSend        (opTxSend),
    .ipTxBusy        (ipTxBusy),
`ifdef UART_TX_FIFO_OVERFLOW_EN
    .opOverflow      (opOverflow),
    .ipOverflowClear (ipOverflowClear),
`endif
    .opCount         (opCount),
    .opEmpty         (opEmpty),
    .opFull          (opFull)
  );

  always #5 ipClk = ~ipClk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ipClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a send request, captures the byte, then plays the UART busy pulse.
  task automatic drainOne(output logic [7:0] b);
    int n = 0;
    while (opTxSend !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("send-rise", 32'(opTxSend), 32'd1);
    b = opTxData;
    ipTxBusy = 1'b1;
    tick();
    check("send-fall", 32'(opTxSend), 32'd0);
    tick();
    ipTxBusy = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] got;
    logic       sawSend;
    int         n;
    ipReset  = 1'b0;
    ipData   = 8'h00;
    ipValid  = 1'b0;
    ipTxBusy = 1'b0;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ipOverflowClear = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    check("rst-send", 32'(opTxSend), 32'd0);
    check("rst-data", 32'(opTxData), 32'h00);
    check("rst-count", 32'(opCount), 32'd0);
    check("rst-empty", 32'(opEmpty), 32'd1);
    check("rst-full", 32'(opFull), 32'd0);
    check("rst-ready", 32'(opReady), 32'd1);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    check("rst-ovf", 32'(opOverflow), 32'd0);
`endif
    ipReset = 1'b1;
    tick();

    // Single byte latency and handshake
    ipValid = 1'b1;
    ipData  = 8'hA5;
    tick();
    ipValid = 1'b0;
    check("t1-count1", 32'(opCount), 32'd1);
    check("t1-nosend", 32'(opTxSend), 32'd0);
    tick();
    check("t1-send", 32'(opTxSend), 32'd1);
    check("t1-data", 32'(opTxData), 32'hA5);
    ipTxBusy = 1'b1;
    tick();
    check("t1-fall", 32'(opTxSend), 32'd0);
    check("t1-count0", 32'(opCount), 32'd0);
    tick();
    check("t1-wait", 32'(opTxSend), 32'd0);
    ipTxBusy = 1'b0;
    tick();
    check("t1-empty", 32'(opEmpty), 32'd1);
    check("t1-datahold", 32'(opTxData), 32'hA5);

    // Fill to capacity while the UART is busy
    ipTxBusy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ipValid = 1'b1;
      ipData  = 8'(i);
      tick();
    end
    ipValid = 1'b0;
    check("t2-full", 32'(opFull), 32'd1);
    check("t2-ready", 32'(opReady), 32'd0);
    check("t2-count", 32'(opCount), 32'd16);
    check("t2-nosend", 32'(opTxSend), 32'd0);

    // Pushes into a full FIFO are dropped
    ipData  = 8'hFF;
    ipValid = 1'b1;
    tick();
    tick();
    tick();
    ipValid = 1'b0;
    check("t3-count", 32'(opCount), 32'd16);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    check("t3-ovf-set", 32'(opOverflow), 32'd1);
    tick();
    check("t3-ovf-sticky", 32'(opOverflow), 32'd1);
    ipValid         = 1'b1;
    ipOverflowClear = 1'b1;
    tick();
    check("t3-ovf-setwins", 32'(opOverflow), 32'd1);
    ipValid = 1'b0;
    tick();
    check("t3-ovf-clear", 32'(opOverflow), 32'd0);
    ipOverflowClear = 1'b0;
`endif

    ipTxBusy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drainOne(got);
      check($sformatf("t2-byte%0d", i), 32'(got), 32'(i));
    end
    check("t2-empty", 32'(opEmpty), 32'd1);
    sawSend = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      sawSend = sawSend | opTxSend;
    end
    check("t3-noFF", 32'(sawSend), 32'd0);

    // Steady level of 5 with push on every pop edge, across pointer wraps
    ipTxBusy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ipValid = 1'b1;
      ipData  = 8'h40 + 8'(i);
      tick();
    end
    ipValid  = 1'b0;
    ipTxBusy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (opTxSend !== 1'b1 && n < 50) begin
        tick();
        n++;
      end
      check("t4-send", 32'(opTxSend), 32'd1);
      check($sformatf("t4-byte%0d", i), 32'(opTxData), 32'h40 + 32'(i));
      ipTxBusy = 1'b1;
      if (i < 35) begin
        ipValid = 1'b1;
        ipData  = 8'h45 + 8'(i);
      end
      tick();
      ipValid = 1'b0;
      if (i < 35) check($sformatf("t4-count%0d", i), 32'(opCount), 32'd5);
      tick();
      ipTxBusy = 1'b0;
      tick();
    end
    check("t4-empty", 32'(opEmpty), 32'd1);

    // Asynchronous reset mid-SEND with bytes queued
    ipTxBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ipValid = 1'b1;
      ipData  = 8'h11 + 8'(i);
      tick();
    end
    ipValid  = 1'b0;
    ipTxBusy = 1'b0;
    tick();
    check("t5-send", 32'(opTxSend), 32'd1);
    check("t5-count4", 32'(opCount), 32'd4);
    ipReset = 1'b0;
    #1;
    check("t5-rst-send", 32'(opTxSend), 32'd0);
    check("t5-rst-count", 32'(opCount), 32'd0);
    check("t5-rst-empty", 32'(opEmpty), 32'd1);
    tick();
    ipReset = 1'b1;
    tick();
    check("t5-idle", 32'(opTxSend), 32'd0);
    ipValid = 1'b1;
    ipData  = 8'h3C;
    tick();
    ipValid = 1'b0;
    drainOne(got);
    check("t5-byte", 32'(got), 32'h3C);
    sawSend = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      sawSend = sawSend | opTxSend;
    end
    check("t5-only", 32'(sawSend), 32'd0);
    check("t5-count", 32'(opCount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
